// File: rtl/sw_array_scheduler.sv
// Two-channel controller that time-shares one toggle-interleaved scoring array and returns tagged scores via a round-robin slot.
// Optional: define SW_SCHED_TIMEOUT_EN to add the DRAIN watchdog timeout.
module sw_array_scheduler #(
  parameter int SCORE_WIDTH = 12,
  parameter int TLEN_WIDTH  = 11,
  parameter int DRAIN_WIDTH = 10,
  parameter int DRAIN_LIMIT = 600
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd0_valid,
  output logic                   cmd0_ready,
  input  logic [TLEN_WIDTH-1:0]  cmd0_len,
  input  logic                   cmd1_valid,
  output logic                   cmd1_ready,
  input  logic [TLEN_WIDTH-1:0]  cmd1_len,
  input  logic                   base0_valid,
  output logic                   base0_ready,
  input  logic [1:0]             base0_data,
  input  logic                   base1_valid,
  output logic                   base1_ready,
  input  logic [1:0]             base1_data,
  input  logic                   arr_toggle,
  output logic                   arr_en0,
  output logic                   arr_en1,
  output logic [1:0]             arr_data,
  input  logic                   arr_vld0,
  input  logic                   arr_vld1,
  input  logic [SCORE_WIDTH-1:0] arr_result0,
  input  logic [SCORE_WIDTH-1:0] arr_result1,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic                   res_chan,
  output logic [SCORE_WIDTH-1:0] res_score,
  output logic                   res_err
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_STREAM, S_DRAIN, S_DONE} state_t;

  if (DRAIN_LIMIT >= (1 << DRAIN_WIDTH)) begin : g_limit_check
    $error("DRAIN_LIMIT does not fit in DRAIN_WIDTH");
  end

  state_t                 st      [2];
  logic [TLEN_WIDTH-1:0]  rem     [2];
  logic [SCORE_WIDTH-1:0] score   [2];
  logic [1:0]             err, granted, vld_q, en;
  logic                   rr_ptr;

  logic [1:0]             cmd_valid, base_valid, vld, own, consume, req;
  logic [TLEN_WIDTH-1:0]  cmd_len   [2];
  logic [1:0]             base_data [2];
  logic [SCORE_WIDTH-1:0] result    [2];
  logic                   res_hs, slot_free, gnt;

`ifdef SW_SCHED_TIMEOUT_EN
  logic [DRAIN_WIDTH-1:0] wd [2];

  function automatic logic [DRAIN_WIDTH-1:0] wd_sat_inc(input logic [DRAIN_WIDTH-1:0] v);
    return (v == DRAIN_WIDTH'(DRAIN_LIMIT)) ? v : v + 1'b1;
  endfunction
`endif

  assign cmd_valid    = {cmd1_valid, cmd0_valid};
  assign base_valid   = {base1_valid, base0_valid};
  assign vld          = {arr_vld1, arr_vld0};
  assign cmd_len[0]   = cmd0_len;
  assign cmd_len[1]   = cmd1_len;
  assign base_data[0] = base0_data;
  assign base_data[1] = base1_data;
  assign result[0]    = arr_result0;
  assign result[1]    = arr_result1;

  assign cmd0_ready  = (st[0] == S_IDLE);
  assign cmd1_ready  = (st[1] == S_IDLE);
  assign base0_ready = consume[0];
  assign base1_ready = consume[1];
  assign arr_en0     = en[0];
  assign arr_en1     = en[1];

  // toggle==1 at an edge means the following cycle is slot 0
  always_comb begin
    own       = {~arr_toggle, arr_toggle};
    consume   = '0;
    req       = '0;
    for (int c = 0; c < 2; c++) begin
      consume[c] = own[c] & base_valid[c] &
                   ((st[c] == S_WAIT) | ((st[c] == S_STREAM) & (rem[c] != '0)));
      req[c]     = (st[c] == S_DONE) & ~granted[c];
    end
    res_hs    = res_valid & res_ready;
    slot_free = ~res_valid | res_ready;
    gnt       = (req[0] & req[1]) ? rr_ptr : req[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        st[c]    <= S_IDLE;
        rem[c]   <= '0;
        score[c] <= '0;
`ifdef SW_SCHED_TIMEOUT_EN
        wd[c]    <= '0;
`endif
      end
      err       <= '0;
      granted   <= '0;
      vld_q     <= '0;
      en        <= '0;
      rr_ptr    <= 1'b0;
      arr_data  <= '0;
      res_valid <= 1'b0;
      res_chan  <= 1'b0;
      res_score <= '0;
      res_err   <= 1'b0;
    end else begin
      vld_q <= vld;
      for (int c = 0; c < 2; c++) begin
        case (st[c])
          S_IDLE: begin
            if (cmd_valid[c]) begin
              err[c] <= 1'b0;
              rem[c] <= cmd_len[c];
              if (cmd_len[c] == '0) begin
                score[c] <= '0;
                st[c]    <= S_DONE;
              end else begin
                st[c]    <= S_WAIT;
              end
            end
          end
          S_WAIT: begin
            if (consume[c]) begin
              en[c]    <= 1'b1;
              arr_data <= base_data[c];
              rem[c]   <= rem[c] - 1'b1;
              st[c]    <= S_STREAM;
            end
          end
          S_STREAM: begin
            if (consume[c]) begin
              arr_data <= base_data[c];
              rem[c]   <= rem[c] - 1'b1;
            end else if (own[c]) begin
              // either the target is complete or the requester starved
              en[c]  <= 1'b0;
              err[c] <= err[c] | (rem[c] != '0);
              st[c]  <= S_DRAIN;
`ifdef SW_SCHED_TIMEOUT_EN
              wd[c]  <= '0;
`endif
            end
          end
          S_DRAIN: begin
            if (vld[c] && !vld_q[c]) begin
              score[c] <= result[c];
              st[c]    <= S_DONE;
            end
`ifdef SW_SCHED_TIMEOUT_EN
            else if (wd[c] == DRAIN_WIDTH'(DRAIN_LIMIT)) begin
              score[c] <= '0;
              err[c]   <= 1'b1;
              st[c]    <= S_DONE;
            end else begin
              wd[c] <= wd_sat_inc(wd[c]);
            end
`endif
          end
          S_DONE: begin
            if (res_hs && (res_chan == 1'(c))) begin
              granted[c] <= 1'b0;
              st[c]      <= S_IDLE;
            end
          end
          default: st[c] <= S_IDLE;
        endcase
      end

      // output slot refills on the same edge it is emptied
      if (slot_free && (req != 2'b00)) begin
        res_valid    <= 1'b1;
        res_chan     <= gnt;
        res_score    <= score[gnt];
        res_err      <= err[gnt];
        granted[gnt] <= 1'b1;
        rr_ptr       <= ~gnt;
      end else if (res_hs) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule
